// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// default frame parameters used by both receiver and (future) transmitter.
package uart_pkg;

    // Receiver/transmitter frame phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Sample ticks per bit and the sample index of the bit centre
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Default frame format: 8 data bits, 1 stop bit (16 sample ticks)
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Both flops reset to
// INIT so that an idle-high line does not look like a falling edge after reset.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values of the synchronizer chain: shift the input through two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops with synchronous reset to INIT
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= INIT;
            sync_q <= INIT;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling. s_tick is a clock enable from the baud
// tick generator. Each bit is sampled at its centre; the completed word is
// presented with a one-cycle strobe and a framing-error flag, all registered.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    // Counter compare points, sized to the counters they are compared against
    localparam logic [4:0] S_MID  = 5'(MID_SAMPLE);
    localparam logic [4:0] S_BIT  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);

    logic rx_s;

    uart_state_e     state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            armed_q, armed_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;

    sync_2ff #(
        .INIT (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM: next state, counters, shift register and registered outputs
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        armed_d = armed_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;

        case (state_q)
            IDLE: begin
                // After a framing error the line must go high again before
                // a low level is trusted as a start bit (break rejection).
                if (!armed_q) begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else begin
                        armed_d = 1'b0;
                    end
                end else if (!rx_s) begin
                    state_d = START;
                    s_d     = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = 5'd0;
                            n_d     = 3'd0;
                        end else begin
                            // Line back high at mid start bit: a glitch
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        s_d = 5'd0;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        if (!rx_s) begin
                            armed_d = 1'b0;
                        end else begin
                            armed_d = armed_q;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end

            default: begin
                state_d = IDLE;
                s_d     = 5'd0;
                n_d     = 3'd0;
            end
        endcase

        // busy is registered so it falls in the same cycle as the strobe
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= 5'd0;
            n_q     <= 3'd0;
            b_q     <= '0;
            armed_q <= 1'b1;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            armed_q <= armed_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: s_tick every 4 clocks (64 clocks per bit).
// Two instances: 8N1 default and a 7-bit / 2-stop-bit variant.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       s_tick;
    logic       rx;
    logic       rx7;
    logic [7:0] dout;
    logic       done;
    logic       ferr;
    logic       busy;
    logic [6:0] dout7;
    logic       done7;
    logic       ferr7;
    logic       busy7;

    int tests_run = 0;
    int fails     = 0;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
        .dout(dout), .rx_done_tick(done), .frame_err(ferr), .busy(busy)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
        .dout(dout7), .rx_done_tick(done7), .frame_err(ferr7), .busy(busy7)
    );

    // Tick generator: one-clock pulse every 4 clocks, changed on the falling edge
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Running clock and tick counts as seen by the DUT at each rising edge
    int cyc        = 0;
    int tick_total = 0;
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        tick_total <= tick_total + (s_tick ? 1 : 0);
    end

    // Monitor for the 8-bit instance
    logic [7:0] q_data[$];
    logic       q_ferr[$];
    int         q_cyc[$];
    int         t0 = 0;
    int         last_ticks = 0;
    int         busy_rises = 0;
    int         width_viol = 0;
    logic       busy_prev = 1'b0;
    logic       done_prev = 1'b0;
    logic       busy_at_strobe = 1'b1;
    logic       busy_before_strobe = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1 && busy_prev === 1'b0) begin
            t0         <= tick_total;
            busy_rises <= busy_rises + 1;
        end
        if (done === 1'b1) begin
            q_data.push_back(dout);
            q_ferr.push_back(ferr);
            q_cyc.push_back(cyc);
            last_ticks         <= tick_total - t0;
            busy_at_strobe     <= busy;
            busy_before_strobe <= busy_prev;
            if (done_prev === 1'b1) width_viol <= width_viol + 1;
        end
        busy_prev <= busy;
        done_prev <= done;
    end

    // Monitor for the 7-bit instance
    logic [6:0] q7_data[$];
    logic       q7_ferr[$];
    int         t0_7 = 0;
    int         last_ticks7 = 0;
    int         width_viol7 = 0;
    logic       busy7_prev = 1'b0;
    logic       done7_prev = 1'b0;
    always @(negedge clk) begin
        if (busy7 === 1'b1 && busy7_prev === 1'b0) t0_7 <= tick_total;
        if (done7 === 1'b1) begin
            q7_data.push_back(dout7);
            q7_ferr.push_back(ferr7);
            last_ticks7 <= tick_total - t0_7;
            if (done7_prev === 1'b1) width_viol7 <= width_viol7 + 1;
        end
        busy7_prev <= busy7;
        done7_prev <= done7;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send8(input logic [7:0] data, input logic stop_val);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (64) @(negedge clk);
        end
        rx = stop_val;
        repeat (64) @(negedge clk);
    endtask

    task automatic send7(input logic [6:0] data);
        rx7 = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rx7 = data[i];
            repeat (64) @(negedge clk);
        end
        rx7 = 1'b1;
        repeat (128) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        rx7   = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", dout); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (ferr !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (dout7 !== 7'h00) begin fails++; $display("FAIL reset_dout7: got %h expected 00", dout7); end
        reset = 1'b0;
        idle(20);
    endtask

    task automatic test_frame_a5();
        int n0 = q_data.size();
        send8(8'hA5, 1'b1);
        idle(64);
        tests_run++; if (q_data.size() !== n0 + 1) begin fails++; $display("FAIL a5_count: got %0d expected %0d", q_data.size(), n0 + 1); end
        if (q_data.size() == n0 + 1) begin
            tests_run++; if (q_data[n0] !== 8'hA5) begin fails++; $display("FAIL a5_data: got %h expected a5", q_data[n0]); end
            tests_run++; if (q_ferr[n0] !== 1'b0) begin fails++; $display("FAIL a5_ferr: got %b expected 0", q_ferr[n0]); end
        end
        tests_run++; if (busy_at_strobe !== 1'b0 || busy_before_strobe !== 1'b1) begin fails++; $display("FAIL a5_busy_fall: got at=%b before=%b expected 0/1", busy_at_strobe, busy_before_strobe); end
        tests_run++; if (last_ticks !== 152) begin fails++; $display("FAIL a5_latency_ticks: got %0d expected 152", last_ticks); end
        tests_run++; if (width_viol !== 0) begin fails++; $display("FAIL a5_strobe_width: got %0d wide strobes expected 0", width_viol); end
        tests_run++; if (dout !== 8'hA5) begin fails++; $display("FAIL a5_dout_hold: got %h expected a5", dout); end
    endtask

    task automatic test_glitch();
        int n0 = q_data.size();
        int r0 = busy_rises;
        rx = 1'b0;
        @(negedge clk);
        idle(100);
        tests_run++; if (busy_rises !== r0 + 1) begin fails++; $display("FAIL glitch_start: got %0d busy rises expected %0d", busy_rises, r0 + 1); end
        tests_run++; if (q_data.size() !== n0) begin fails++; $display("FAIL glitch_no_strobe: got %0d strobes expected %0d", q_data.size(), n0); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        tests_run++; if (dout !== 8'hA5) begin fails++; $display("FAIL glitch_dout: got %h expected a5", dout); end
    endtask

    task automatic test_framing();
        int n0 = q_data.size();
        int r0;
        send8(8'h3C, 1'b0);
        r0 = busy_rises;
        rx = 1'b0;
        repeat (40 * 64) @(negedge clk);
        tests_run++; if (q_data.size() !== n0 + 1) begin fails++; $display("FAIL break_count: got %0d expected %0d", q_data.size(), n0 + 1); end
        if (q_data.size() >= n0 + 1) begin
            tests_run++; if (q_data[n0] !== 8'h3C) begin fails++; $display("FAIL ferr_data: got %h expected 3c", q_data[n0]); end
            tests_run++; if (q_ferr[n0] !== 1'b1) begin fails++; $display("FAIL ferr_flag: got %b expected 1", q_ferr[n0]); end
        end
        tests_run++; if (busy_rises !== r0) begin fails++; $display("FAIL break_rearm: got %0d busy rises expected %0d", busy_rises, r0); end
        tests_run++; if (ferr !== 1'b1) begin fails++; $display("FAIL ferr_hold: got %b expected 1", ferr); end
        idle(128);
        send8(8'h11, 1'b1);
        idle(64);
        tests_run++; if (q_data.size() !== n0 + 2) begin fails++; $display("FAIL after_break_count: got %0d expected %0d", q_data.size(), n0 + 2); end
        if (q_data.size() == n0 + 2) begin
            tests_run++; if (q_data[n0 + 1] !== 8'h11) begin fails++; $display("FAIL after_break_data: got %h expected 11", q_data[n0 + 1]); end
            tests_run++; if (q_ferr[n0 + 1] !== 1'b0) begin fails++; $display("FAIL after_break_ferr: got %b expected 0", q_ferr[n0 + 1]); end
        end
    endtask

    task automatic test_back_to_back();
        int n0 = q_data.size();
        send8(8'h00, 1'b1);
        send8(8'hFF, 1'b1);
        idle(64);
        tests_run++; if (q_data.size() !== n0 + 2) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", q_data.size(), n0 + 2); end
        if (q_data.size() == n0 + 2) begin
            tests_run++; if (q_data[n0] !== 8'h00 || q_data[n0 + 1] !== 8'hFF) begin fails++; $display("FAIL b2b_data: got %h,%h expected 00,ff", q_data[n0], q_data[n0 + 1]); end
            tests_run++; if (q_ferr[n0] !== 1'b0 || q_ferr[n0 + 1] !== 1'b0) begin fails++; $display("FAIL b2b_ferr: got %b,%b expected 0,0", q_ferr[n0], q_ferr[n0 + 1]); end
            tests_run++; if (q_cyc[n0 + 1] - q_cyc[n0] !== 640) begin fails++; $display("FAIL b2b_spacing: got %0d clocks expected 640", q_cyc[n0 + 1] - q_cyc[n0]); end
        end
    endtask

    task automatic test_reset_midframe();
        int n0 = q_data.size();
        logic [7:0] v;
        v  = 8'h5A;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = v[i];
            repeat (64) @(negedge clk);
        end
        rx = v[4];
        repeat (32) @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL midframe_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        tests_run++; if (dout !== 8'h00) begin fails++; $display("FAIL midframe_dout: got %h expected 00", dout); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL midframe_busy: got %b expected 0", busy); end
        idle(400);
        tests_run++; if (q_data.size() !== n0) begin fails++; $display("FAIL midframe_no_strobe: got %0d expected %0d", q_data.size(), n0); end
        send8(8'hC3, 1'b1);
        idle(64);
        tests_run++; if (q_data.size() !== n0 + 1) begin fails++; $display("FAIL c3_count: got %0d expected %0d", q_data.size(), n0 + 1); end
        if (q_data.size() == n0 + 1) begin
            tests_run++; if (q_data[n0] !== 8'hC3) begin fails++; $display("FAIL c3_data: got %h expected c3", q_data[n0]); end
            tests_run++; if (q_ferr[n0] !== 1'b0) begin fails++; $display("FAIL c3_ferr: got %b expected 0", q_ferr[n0]); end
        end
    endtask

    task automatic test_dbit7();
        int m0 = q7_data.size();
        send7(7'h55);
        repeat (64) @(negedge clk);
        tests_run++; if (q7_data.size() !== m0 + 1) begin fails++; $display("FAIL d7_count: got %0d expected %0d", q7_data.size(), m0 + 1); end
        if (q7_data.size() == m0 + 1) begin
            tests_run++; if (q7_data[m0] !== 7'h55) begin fails++; $display("FAIL d7_data: got %h expected 55", q7_data[m0]); end
            tests_run++; if (q7_ferr[m0] !== 1'b0) begin fails++; $display("FAIL d7_ferr: got %b expected 0", q7_ferr[m0]); end
        end
        tests_run++; if (last_ticks7 !== 152) begin fails++; $display("FAIL d7_latency_ticks: got %0d expected 152", last_ticks7); end
        tests_run++; if (busy7 !== 1'b0) begin fails++; $display("FAIL d7_busy: got %b expected 0", busy7); end
        tests_run++; if (width_viol7 !== 0 || width_viol !== 0) begin fails++; $display("FAIL strobe_width_all: got %0d/%0d expected 0/0", width_viol, width_viol7); end
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        rx7   = 1'b1;
        @(negedge clk);
        test_reset();
        test_frame_a5();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_dbit7();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
